// File: rtl/uart_tx_feeder_pkg.sv
// Shared types for the uart_tx feeder: sequencer state encoding and data width.
package uart_tx_feeder_pkg;

   localparam int DATA_W = 8;

   typedef enum logic [1:0] {
      FEED_IDLE = 2'd0,
      FEED_SEND = 2'd1,
      FEED_WAIT = 2'd2
   } feed_state_t;

endpackage

// File: rtl/uart_tx_feeder_sync_fifo.sv
// Byte FIFO with extra-MSB pointers; flush moves the read pointer onto the write pointer.
module sync_fifo #(
   parameter int ADDR_W = 4,
   parameter int DATA_W = 8
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              wr,
   input  logic [DATA_W-1:0] wr_data,
   input  logic              rd,
   input  logic              flush,
   output logic [DATA_W-1:0] rd_data,
   output logic              full,
   output logic              empty,
   output logic [ADDR_W:0]   count
);

   localparam int DEPTH = 2**ADDR_W;

   logic [ADDR_W:0]   wr_ptr;
   logic [ADDR_W:0]   rd_ptr;
   logic [DATA_W-1:0] mem [DEPTH];
   logic              do_wr;
   logic              do_rd;

   // full is evaluated on the pre-pop pointers, so a push into a full FIFO is dropped even when a pop coincides
   assign do_wr = wr & ~full & ~flush;
   assign do_rd = rd & ~empty & ~flush;

   always_ff @(posedge clk) begin
      if (do_wr) mem[wr_ptr[ADDR_W-1:0]] <= wr_data;
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
      end else begin
         if (do_wr) wr_ptr <= wr_ptr + (ADDR_W+1)'(1);
         if (flush)      rd_ptr <= wr_ptr;
         else if (do_rd) rd_ptr <= rd_ptr + (ADDR_W+1)'(1);
      end
   end

   assign full    = (wr_ptr[ADDR_W] != rd_ptr[ADDR_W]) &&
                    (wr_ptr[ADDR_W-1:0] == rd_ptr[ADDR_W-1:0]);
   assign empty   = (wr_ptr == rd_ptr);
   assign count   = wr_ptr - rd_ptr;
   assign rd_data = mem[rd_ptr[ADDR_W-1:0]];

endmodule

// File: rtl/uart_tx_feeder.sv
// Byte FIFO plus send sequencer feeding uart_tx one byte at a time, using tx_ready as flow control.
//
//  state     | meaning
//  ----------+-------------------------------------------------------------
//  FEED_IDLE | no byte handed over; pops the head when queued and tx_ready
//  FEED_SEND | tx_send held high until uart_tx drops ready (byte accepted)
//  FEED_WAIT | uart_tx shifting the byte out; wait for ready to return
module uart_tx_feeder
   import uart_tx_feeder_pkg::*;
#(
   parameter int ADDR_W = 4
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              wr_en,
   input  logic [DATA_W-1:0] wr_data,
   input  logic              flush,
   output logic              full,
   output logic              empty,
   output logic [ADDR_W:0]   count,
   output logic              overflow,
   output logic              busy,
   output logic [DATA_W-1:0] tx_data,
   output logic              tx_send,
   input  logic              tx_ready
);

   feed_state_t       state;
   feed_state_t       state_nxt;
   logic              pop;
   logic [DATA_W-1:0] head;

   sync_fifo #(
      .ADDR_W (ADDR_W),
      .DATA_W (DATA_W)
   ) u_fifo (
      .clk     (clk),
      .rst     (rst),
      .wr      (wr_en),
      .wr_data (wr_data),
      .rd      (pop),
      .flush   (flush),
      .rd_data (head),
      .full    (full),
      .empty   (empty),
      .count   (count)
   );

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) state <= FEED_IDLE;
      else      state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      pop       = 1'b0;
      case (state)
         FEED_IDLE: begin
            if (!empty && tx_ready && !flush) begin
               pop       = 1'b1;
               state_nxt = FEED_SEND;
            end
         end
         FEED_SEND: if (!tx_ready) state_nxt = FEED_WAIT;
         FEED_WAIT: if (tx_ready)  state_nxt = FEED_IDLE;
         default:   state_nxt = FEED_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         tx_data  <= '0;
         overflow <= 1'b0;
      end else begin
         if (pop) tx_data <= head;
         overflow <= wr_en & full & ~flush;
      end
   end

   // decoded from the state flop, so tx_send is glitch-free toward uart_tx
   assign tx_send = (state == FEED_SEND);
   assign busy    = ~empty | (state != FEED_IDLE);

endmodule
